// File: rtl/ds_pkg.sv
// Shared constants and FSM encoding for the decimated-sample capture path.
package ds_pkg;
    localparam int DATA_WIDTH_DEF = 14;
    localparam int DEPTH_LOG2_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } fc_state_e;
endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered read.
// The read register only loads on re, so it doubles as a holding stage.
module sdp_ram #(
    parameter int DW = 14,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/frame_capture.sv
// Triggered single-frame capture into block RAM, then in-order readout with valid/ready.
// Define FRAME_CAPTURE_LEVEL_TRIG_EN for rising-crossing level trigger; default triggers on the first sample in ARM.
module frame_capture
    import ds_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_en,
    output logic                  busy,
    input  logic                  arm,
    input  logic [DATA_WIDTH-1:0] trig_level,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic                  frame_done,
    output logic [1:0]            state
);
    localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = '1;

    fc_state_e             st;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   rd_cnt;
    logic                  q_vld, q_last;
    logic [DATA_WIDTH-1:0] q_data;
    logic                  accept, trig, we, re, out_adv, rd_hs;
    logic [DEPTH_LOG2-1:0] waddr;

    assign state   = st;
    assign busy    = (st == ST_IDLE) || (st == ST_DRAIN);
    assign accept  = in_en & ~busy;
    assign out_adv = ~rd_valid | rd_ready;
    assign rd_hs   = rd_valid & rd_ready;

`ifdef FRAME_CAPTURE_LEVEL_TRIG_EN
    logic [DATA_WIDTH-1:0] prev;
    logic                  have_prev;

    assign trig = accept && (st == ST_ARM) && have_prev &&
                  (prev < trig_level) && (in_data >= trig_level);

    // First accepted sample in ARM only seeds prev; it can never trigger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev      <= '0;
            have_prev <= 1'b0;
        end else if (st != ST_ARM) begin
            have_prev <= 1'b0;
        end else if (accept) begin
            prev      <= in_data;
            have_prev <= 1'b1;
        end
    end
`else
    logic unused_trig_level;
    assign unused_trig_level = ^trig_level;
    assign trig = accept && (st == ST_ARM);
`endif

    assign we    = trig || (accept && (st == ST_CAPTURE));
    assign waddr = (st == ST_ARM) ? '0 : wr_ptr;
    // Issue a read whenever the RAM output stage is empty or drains this cycle.
    assign re    = (st == ST_DRAIN) && !rd_cnt[DEPTH_LOG2] && (!q_vld || out_adv);

    sdp_ram #(.DW(DATA_WIDTH), .AW(DEPTH_LOG2)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (in_data),
        .re    (re),
        .raddr (rd_cnt[DEPTH_LOG2-1:0]),
        .rdata (q_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= ST_IDLE;
            wr_ptr     <= '0;
            rd_cnt     <= '0;
            q_vld      <= 1'b0;
            q_last     <= 1'b0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            rd_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (st)
                ST_IDLE: begin
                    wr_ptr <= '0;
                    if (arm) st <= ST_ARM;
                end
                ST_ARM: begin
                    if (trig) begin
                        st     <= ST_CAPTURE;
                        wr_ptr <= DEPTH_LOG2'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (accept) begin
                        if (wr_ptr == LAST_ADDR) st <= ST_DRAIN;
                        else wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                    end
                end
                ST_DRAIN: begin
                    if (rd_hs && rd_last) begin
                        st         <= ST_IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: st <= ST_IDLE;
            endcase

            if (st != ST_DRAIN) rd_cnt <= '0;
            else if (re) rd_cnt <= rd_cnt + (DEPTH_LOG2+1)'(1);

            if (re) begin
                q_vld  <= 1'b1;
                q_last <= (rd_cnt[DEPTH_LOG2-1:0] == LAST_ADDR);
            end else if (out_adv) begin
                q_vld  <= 1'b0;
            end

            if (out_adv) begin
                rd_valid <= q_vld;
                rd_last  <= q_vld & q_last;
                if (q_vld) rd_data <= q_data;
            end
        end
    end
endmodule

// File: tb/tb_frame_capture.sv
// Randomized directed-step bench for frame_capture (DATA_WIDTH=14, DEPTH_LOG2=3) with a queue-based frame model.
module tb_frame_capture;
    localparam int DW = 14;
    localparam int AL = 3;
    localparam int DEPTH = 1 << AL;
    localparam logic [DW-1:0] LVL = 14'd8192;

    logic          clk = 1'b0;
    logic          rst, in_en, arm, rd_ready;
    logic [DW-1:0] in_data, trig_level, rd_data;
    logic          busy, rd_valid, rd_last, frame_done;
    logic [1:0]    state;

    frame_capture #(.DATA_WIDTH(DW), .DEPTH_LOG2(AL)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_en(in_en), .busy(busy),
        .arm(arm), .trig_level(trig_level), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_last(rd_last), .frame_done(frame_done), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sent[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    int got_last[$];
    bit arm_hold = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Index in sent[] of the sample that lands at address 0, or -1 if none yet.
    function automatic int trig_start();
`ifdef FRAME_CAPTURE_LEVEL_TRIG_EN
        for (int i = 1; i < sent.size(); i++)
            if (sent[i-1] < LVL && sent[i] >= LVL) return i;
        return -1;
`else
        return 0;
`endif
    endfunction

    function automatic int written();
        int s;
        s = trig_start();
        if (s < 0) return 0;
        return (sent.size() - s > DEPTH) ? DEPTH : sent.size() - s;
    endfunction

    function automatic void build_exp();
        int s;
        s = trig_start();
        exp_q.delete();
        for (int k = 0; k < DEPTH; k++)
            if (s >= 0 && s + k < sent.size()) exp_q.push_back(sent[s+k]);
    endfunction

    function automatic logic [DW-1:0] directed(input int n);
`ifdef FRAME_CAPTURE_LEVEL_TRIG_EN
        return DW'(8000 + 100 * n);
`else
        return DW'(100 + n);
`endif
    endfunction

    task automatic send(input logic [DW-1:0] v, input int gap, input bit arm_noise);
        int w, est, g;
        in_data = v;
        in_en = 1'b1;
        if (arm_noise) arm = 1'b1;
        tick();
        in_en = 1'b0;
        arm = arm_hold;
        sent.push_back(v);
        w = written();
        est = (w == 0) ? 1 : (w < DEPTH ? 2 : 3);
        chk("state_after_sample", 32'(state), 32'(est));
        chk("busy_after_sample", 32'(busy), 32'(est == 3));
        g = (gap == 0) ? int'($urandom_range(1, 3)) : gap;
        if (w < DEPTH)
            for (int i = 1; i < g; i++) begin
                if (arm_noise) arm = 1'($urandom);
                in_en = (state == 2'd0) ? 1'($urandom) : 1'b0;
                tick();
                arm = arm_hold;
                in_en = 1'b0;
            end
    endtask

    task automatic capture(input int gap, input bit dir, input bit arm_noise, input int stop_at);
        int n = 0;
        while (written() < stop_at && n < 300) begin
            send(dir ? directed(n) : DW'($urandom), gap, arm_noise);
            n++;
        end
        chk("capture_bound", 32'(n < 300), 32'd1);
    endtask

    task automatic start_frame();
        arm = 1'b1;
        tick();
        arm = arm_hold;
        sent.delete();
        chk("arm_state", 32'(state), 32'd1);
        chk("arm_busy", 32'(busy), 32'd0);
    endtask

    task automatic drain(input int mode, input bit noise);
        int cyc = 0, first_v = -1, first_hs = -1, last_hs = -1;
        bit done = 0, pv = 0, pr = 0, hs, lastflag;
        logic [DW-1:0] pd = '0;
        logic pl = 1'b0;
        got_q.delete();
        got_last.delete();
        while (!done && cyc < 400) begin
            case (mode)
                0: rd_ready = 1'b1;
                1: rd_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rd_ready = 1'($urandom);
            endcase
            if (noise) begin
                in_en = 1'($urandom);
                in_data = DW'($urandom);
                arm = 1'($urandom);
            end
            if (pv && !pr) begin
                chk("hold_valid", 32'(rd_valid), 32'd1);
                chk("hold_data", 32'(rd_data), 32'(pd));
                chk("hold_last", 32'(rd_last), 32'(pl));
            end
            if (rd_valid && first_v < 0) first_v = cyc;
            hs = rd_valid && rd_ready;
            if (hs) begin
                got_q.push_back(rd_data);
                got_last.push_back(int'(rd_last));
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            pv = rd_valid; pr = rd_ready; pd = rd_data; pl = rd_last;
            lastflag = hs && rd_last;
            tick();
            cyc++;
            in_en = 1'b0;
            arm = arm_hold;
            if (lastflag) begin
                done = 1;
                chk("frame_done_pulse", 32'(frame_done), 32'd1);
                chk("state_at_done", 32'(state), 32'd0);
            end else begin
                chk("no_early_done", 32'(frame_done), 32'd0);
            end
        end
        rd_ready = 1'b0;
        chk("drain_bound", 32'(done), 32'd1);
        chk("first_valid_latency", 32'(first_v >= 0 && first_v <= 2), 32'd1);
        chk("frame_len", 32'(got_q.size()), 32'(exp_q.size()));
        chk("model_len", 32'(exp_q.size()), 32'(DEPTH));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk("frame_data", 32'(got_q[i]), 32'(exp_q[i]));
            chk("rd_last_pos", 32'(got_last[i]), 32'(i == DEPTH - 1));
        end
        if (mode == 0) chk("throughput", 32'(last_hs - first_hs), 32'(DEPTH - 1));
    endtask

    task automatic post_frame();
        tick();
        chk("done_one_cycle", 32'(frame_done), 32'd0);
        chk("state_after_frame", 32'(state), arm_hold ? 32'd1 : 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_en = 1'b0; arm = 1'b0; rd_ready = 1'b0;
        in_data = '0; trig_level = LVL;
        repeat (3) tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_last", 32'(rd_last), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        tick();

        // in_en while idle is ignored
        in_data = 14'd5; in_en = 1'b1;
        tick();
        in_en = 1'b0;
        chk("idle_ignore_in_en", 32'(state), 32'd0);

        // directed frame, one sample every 16 cycles
        start_frame();
        capture(16, 1'b1, 1'b0, DEPTH);
        build_exp();
        drain(0, 1'b0);
        post_frame();

        // backpressure 1,0,0,1
        start_frame();
        capture(0, 1'b0, 1'b0, DEPTH);
        build_exp();
        drain(1, 1'b0);
        post_frame();

        // ignored arm/in_en during capture and drain
        start_frame();
        capture(0, 1'b0, 1'b1, DEPTH);
        build_exp();
        drain(2, 1'b1);
        post_frame();

        // reset after four writes, then a clean frame
        start_frame();
        capture(0, 1'b0, 1'b0, 4);
        rst = 1'b1;
        #1;
        chk("midcap_rst_state", 32'(state), 32'd0);
        chk("midcap_rst_busy", 32'(busy), 32'd1);
        chk("midcap_rst_valid", 32'(rd_valid), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("midcap_rst_idle", 32'(state), 32'd0);
        start_frame();
        capture(2, 1'b0, 1'b0, DEPTH);
        build_exp();
        drain(2, 1'b0);
        post_frame();

        // reset mid-drain: no frame_done afterwards
        start_frame();
        capture(1, 1'b0, 1'b0, DEPTH);
        rd_ready = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("middrain_rst_valid", 32'(rd_valid), 32'd0);
        chk("middrain_rst_state", 32'(state), 32'd0);
        tick();
        rst = 1'b0;
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("middrain_no_done", 32'(frame_done), 32'd0);
        end

        // back-to-back frames with arm held high
        arm_hold = 1'b1;
        start_frame();
        capture(0, 1'b0, 1'b0, DEPTH);
        build_exp();
        drain(0, 1'b0);
        post_frame();
        sent.delete();
        capture(0, 1'b0, 1'b0, DEPTH);
        build_exp();
        drain(2, 1'b0);
        post_frame();
        arm_hold = 1'b0;
        arm = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_capture.md
FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 14, meaning the sample width, matching the decimator output.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10, meaning the frame length is 2^DEPTH_LOG2 samples.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_data, input, DATA_WIDTH bits: unsigned (offset-binary) decimated sample.
REQ-006 SHALL have port in_en, input, 1 bit: one-cycle strobe qualifying in_data.
REQ-007 SHALL have port busy, output, 1 bit: wired to the decimator's outbusy; high means no sample is accepted.
REQ-008 SHALL have port arm, input, 1 bit: start-capture request.
REQ-009 SHALL have port trig_level, input, DATA_WIDTH bits: unsigned trigger threshold.
REQ-010 SHALL have port rd_data, output, DATA_WIDTH bits: readout sample.
REQ-011 SHALL have port rd_valid, output, 1 bit: rd_data is valid.
REQ-012 SHALL have port rd_ready, input, 1 bit: consumer accepts rd_data.
REQ-013 SHALL have port rd_last, output, 1 bit: marks the final sample of the frame, qualified by rd_valid.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse when the frame is fully drained.
REQ-015 SHALL have port state, output, 2 bits: current FSM state, as IDLE=0, ARM=1, CAPTURE=2, DRAIN=3.

Function
REQ-016 SHALL implement the FSM IDLE -> ARM on arm=1; ARM -> CAPTURE on trigger; CAPTURE -> DRAIN after the 2^DEPTH_LOG2-th accepted write; DRAIN -> IDLE on the rd_last handshake.
REQ-017 SHALL drive busy=1 in IDLE and DRAIN, and busy=0 in ARM and CAPTURE, decoded from the registered state.
REQ-018 SHALL ignore in_en while busy=1.
REQ-019 SHALL ignore arm in any state other than IDLE.
REQ-020 SHALL, in CAPTURE, write each accepted sample to RAM at wr_ptr and then increment wr_ptr, which starts at 0.
REQ-021 SHALL enter DRAIN in the cycle after the write to address 2^DEPTH_LOG2-1, and SHALL not wrap wr_ptr.
REQ-022 SHALL, in DRAIN, present addresses 0..2^DEPTH_LOG2-1 in order, with a RAM read latency of 1 cycle and registered outputs.
REQ-023 SHALL assert the first rd_valid no later than 2 cycles after entering DRAIN.
REQ-024 SHALL hold rd_data, rd_valid and rd_last stable while rd_valid=1 and rd_ready=0, and SHALL never drop or repeat a sample.
REQ-025 SHALL sustain one sample per cycle while rd_ready is held at 1.
REQ-026 SHALL assert rd_last with address 2^DEPTH_LOG2-1.
REQ-027 SHALL pulse frame_done in the cycle after the rd_last handshake, in which state is IDLE.
REQ-028 SHALL, when arm=1 coincides with the frame_done cycle (state IDLE), go to ARM; back-to-back frames are legal.

Reset
REQ-029 SHALL, on rst, set state=IDLE, busy=1, rd_valid=0, rd_last=0, frame_done=0, rd_data=0, pointers=0 and the previous-sample register=0, with RAM contents not reset.
REQ-030 SHALL, on rst asserted mid-CAPTURE or mid-DRAIN, abandon the frame immediately, and SHALL not emit frame_done.

Configuration
REQ-031 SHALL, with macro FRAME_CAPTURE_LEVEL_TRIG_EN defined, trigger in ARM on a rising crossing of an accepted sample, defined as prev < trig_level and cur >= trig_level, where prev is the previous accepted sample in ARM.
REQ-032 SHALL, with FRAME_CAPTURE_LEVEL_TRIG_EN defined, treat the first accepted sample after entering ARM as prev only, never as a trigger.
REQ-033 SHALL, with FRAME_CAPTURE_LEVEL_TRIG_EN defined, write the triggering sample as address 0 in the same cycle as the ARM -> CAPTURE transition.
REQ-034 SHALL, with FRAME_CAPTURE_LEVEL_TRIG_EN undefined, treat the first accepted in_en in ARM as the trigger and write it to address 0, leaving trig_level unused but present.

Structure
REQ-035 SHALL place the state enum encoding and the default DATA_WIDTH/DEPTH_LOG2 constants in the shared package ds_pkg.
REQ-036 SHALL implement the storage as one sub-module sdp_ram: a simple dual-port RAM with one write port, one read port and a registered 1-cycle read, inferred as block RAM.

Verification (DATA_WIDTH=14, DEPTH_LOG2=3)
REQ-037 SHALL verify no trigger macro: arm, then in_en every 16 cycles with data 100..107 -> busy falls in ARM and rises after the 8th write; with rd_ready=1, rd_data reads 100..107, rd_last on 107, frame_done 1 cycle later.
REQ-038 SHALL verify FRAME_CAPTURE_LEVEL_TRIG_EN with trig_level=8192 and samples 8000, 8100, 8200, 8300, ... -> 8200 is captured at address 0; 8000 and 8100 are not stored.
REQ-039 SHALL verify backpressure: rd_ready toggling 1,0,0,1 during DRAIN -> rd_data is held across the stall, with no loss or duplication across 8 samples.
REQ-040 SHALL verify ignored events: arm pulsed in CAPTURE and DRAIN, and in_en strobed in IDLE and DRAIN -> state sequence unchanged and frame contents unchanged.
REQ-041 SHALL verify reset mid-operation: rst asserted after 4 writes -> state=0, busy=1, rd_valid=0 immediately; a new arm captures a full, correct frame.
REQ-042 SHALL verify back-to-back frames: arm held at 1 through frame_done -> re-enters ARM in the same cycle, and the second frame is correct.
